dmem_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single-port dmem between NREQ CPU cores.

---
 rtl/dmem_arbiter_if.sv | 34 +++
 rtl/dmem_arbiter.sv | 152 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the per-core ld/st logic, the dmem macro and dmem_arbiter.
// slave  : arbiter view (takes requests and mem_q, drives acks and the dmem port)
// master : requester/memory-side view (drives requests and mem_q)
interface dmem_arbiter_if #(
  parameter int NREQ = 4,
  parameter int AW   = 16,
  parameter int DW   = 16
);
  localparam int IDW = $clog2(NREQ);

  logic                 stop;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      we;
  logic [NREQ*AW-1:0]   addr;
  logic [NREQ*DW-1:0]   wdata;
  logic [NREQ-1:0]      ack;
  logic [DW-1:0]        rdata;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_data;
  logic                 mem_wren;
  logic [DW-1:0]        mem_q;
  logic                 busy;
  logic [IDW-1:0]       gnt_id;

  modport slave (
    input  stop, req, we, addr, wdata, mem_q,
    output ack, rdata, mem_addr, mem_data, mem_wren, busy, gnt_id
  );

  modport master (
    output stop, req, we, addr, wdata, mem_q,
    input  ack, rdata, mem_addr, mem_data, mem_wren, busy, gnt_id
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing the single-port dmem between NREQ cores.
// IDLE -> ACCESS -> RESP -> (ACCESS | IDLE); one access every two cycles back to back.
// Optional build macro: DMEM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// instead of round-robin; the rotating pointer is then tied to 0.
module dmem_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 16,
  parameter int DW   = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  dmem_arbiter_if.slave    bus
);
  localparam int IDW = $clog2(NREQ);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]      state_q,    state_d;
  logic [IDW-1:0]  gnt_id_q,   gnt_id_d;
  logic [AW-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DW-1:0]   cmd_data_q, cmd_data_d;
  logic            cmd_we_q,   cmd_we_d;
  logic [DW-1:0]   rdata_q,    rdata_d;

  logic [IDW-1:0]  rr_ptr;
  logic [IDW-1:0]  rr_next;
  logic [NREQ-1:0] eligible;
  logic            win_vld;
  logic [IDW-1:0]  win_id;
  logic            grant;
  logic [NREQ-1:0] ack;
  int              idx;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Fixed priority: search always starts at core 0.
  assign rr_ptr = '0;
`else
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  // Pointer advances past each winner so every core gets a turn.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant) rr_ptr_d = rr_next;
  end

  // Round-robin pointer register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;
`endif

  // Requests that may be granted now; the core just acked is masked for its ack cycle only.
  always_comb begin
    eligible = '0;
    if (state_q == ST_IDLE)
      eligible = bus.req;
    else if (state_q == ST_RESP)
      eligible = bus.req & ~(NREQ'(1) << gnt_id_q);
  end

  // Search from rr_ptr upward with wrap; first set bit wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!win_vld && eligible[IDW'(idx)]) begin
        win_vld = 1'b1;
        win_id  = IDW'(idx);
      end
    end
  end

  assign grant   = win_vld && !bus.stop;
  assign rr_next = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + IDW'(1);

  // FSM next state, command capture on grant, load data capture at end of ACCESS.
  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    cmd_addr_d = cmd_addr_q;
    cmd_data_d = cmd_data_q;
    cmd_we_d   = cmd_we_q;
    rdata_d    = rdata_q;

    if (grant) begin
      gnt_id_d   = win_id;
      cmd_addr_d = bus.addr[int'(win_id)*AW +: AW];
      cmd_data_d = bus.wdata[int'(win_id)*DW +: DW];
      cmd_we_d   = bus.we[win_id];
    end

    case (state_q)
      ST_IDLE: begin
        if (grant) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (!cmd_we_q) rdata_d = bus.mem_q;
      end
      ST_RESP: begin
        state_d = grant ? ST_ACCESS : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and command registers; reset aborts any access in flight.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= ST_IDLE;
      gnt_id_q   <= '0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
      cmd_we_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      gnt_id_q   <= gnt_id_d;
      cmd_addr_q <= cmd_addr_d;
      cmd_data_q <= cmd_data_d;
      cmd_we_q   <= cmd_we_d;
      rdata_q    <= rdata_d;
    end
  end

  // One-hot ack to the granted core during RESP.
  always_comb begin
    ack = '0;
    if (state_q == ST_RESP) ack[gnt_id_q] = 1'b1;
  end

  assign bus.ack      = ack;
  assign bus.rdata    = rdata_q;
  assign bus.mem_addr = cmd_addr_q;
  assign bus.mem_data = cmd_data_q;
  assign bus.mem_wren = (state_q == ST_ACCESS) && cmd_we_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.gnt_id   = gnt_id_q;

  // Protocol invariants.
  a_ack_onehot: assert property (@(posedge CLK) disable iff (!RSTN) $onehot0(bus.ack));
  a_wren_access: assert property (@(posedge CLK) disable iff (!RSTN)
                                  bus.mem_wren |-> (state_q == ST_ACCESS));

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (NREQ=4, AW=16, DW=16).
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rstn;
  int   n_cmp = 0;
  int   n_err = 0;

  dmem_arbiter_if #(.NREQ(4), .AW(16), .DW(16)) bus ();

  dmem_arbiter #(.NREQ(4), .AW(16), .DW(16)) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int core, input logic w, input logic [15:0] a, input logic [15:0] d);
    bus.we[core]           = w;
    bus.addr[core*16 +: 16]  = a;
    bus.wdata[core*16 +: 16] = d;
  endtask

  task automatic test_reset();
    rstn      = 1'b0;
    bus.stop  = 1'b0;
    bus.req   = 4'hF;
    bus.we    = 4'hF;
    bus.addr  = {4{16'hAAAA}};
    bus.wdata = {4{16'h5555}};
    bus.mem_q = 16'h1111;
    step();
    step();
    n_cmp++; if (bus.ack !== 4'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0000", bus.ack); end
    n_cmp++; if (bus.rdata !== 16'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0000", bus.rdata); end
    n_cmp++; if (bus.mem_wren !== 1'b0) begin n_err++; $display("FAIL rst_wren: got %b want 0", bus.mem_wren); end
    n_cmp++; if (bus.mem_addr !== 16'h0) begin n_err++; $display("FAIL rst_maddr: got %h want 0000", bus.mem_addr); end
    n_cmp++; if (bus.mem_data !== 16'h0) begin n_err++; $display("FAIL rst_mdata: got %h want 0000", bus.mem_data); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.gnt_id !== 2'd0) begin n_err++; $display("FAIL rst_gnt: got %0d want 0", bus.gnt_id); end
    bus.req = 4'h0;
    bus.we  = 4'h0;
    rstn    = 1'b1;
    step();
    step();
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_single_load();
    set_cmd(2, 1'b0, 16'h0040, 16'h0);
    bus.mem_q = 16'hBEEF;
    bus.req   = 4'b0100;
    step();
    n_cmp++; if (bus.mem_addr !== 16'h0040) begin n_err++; $display("FAIL ld_addr: got %h want 0040", bus.mem_addr); end
    n_cmp++; if (bus.mem_wren !== 1'b0) begin n_err++; $display("FAIL ld_wren: got %b want 0", bus.mem_wren); end
    n_cmp++; if (bus.gnt_id !== 2'd2) begin n_err++; $display("FAIL ld_gnt: got %0d want 2", bus.gnt_id); end
    n_cmp++; if (bus.ack !== 4'b0) begin n_err++; $display("FAIL ld_early_ack: got %b want 0000", bus.ack); end
    step();
    n_cmp++; if (bus.ack !== 4'b0100) begin n_err++; $display("FAIL ld_ack: got %b want 0100", bus.ack); end
    n_cmp++; if (bus.rdata !== 16'hBEEF) begin n_err++; $display("FAIL ld_rdata: got %h want beef", bus.rdata); end
    bus.req   = 4'b0;
    bus.mem_q = 16'h0;
    step();
    n_cmp++; if (bus.ack !== 4'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL ld_done: got ack %b busy %b want 0000 0", bus.ack, bus.busy); end
  endtask

  task automatic test_single_store();
    set_cmd(0, 1'b1, 16'h0010, 16'h1234);
    bus.mem_q = 16'hDEAD;
    bus.req   = 4'b0001;
    step();
    // change core0 inputs mid-access; the registered command must not follow
    set_cmd(0, 1'b0, 16'hFFFF, 16'hFFFF);
    #1;
    n_cmp++; if (bus.mem_wren !== 1'b1) begin n_err++; $display("FAIL st_wren: got %b want 1", bus.mem_wren); end
    n_cmp++; if (bus.mem_addr !== 16'h0010) begin n_err++; $display("FAIL st_addr: got %h want 0010", bus.mem_addr); end
    n_cmp++; if (bus.mem_data !== 16'h1234) begin n_err++; $display("FAIL st_data: got %h want 1234", bus.mem_data); end
    step();
    n_cmp++; if (bus.ack !== 4'b0001) begin n_err++; $display("FAIL st_ack: got %b want 0001", bus.ack); end
    n_cmp++; if (bus.mem_wren !== 1'b0) begin n_err++; $display("FAIL st_wren_resp: got %b want 0", bus.mem_wren); end
    n_cmp++; if (bus.rdata !== 16'hBEEF) begin n_err++; $display("FAIL st_rdata_kept: got %h want beef", bus.rdata); end
    bus.req = 4'b0;
    bus.we  = 4'b0;
    step();
    n_cmp++; if (bus.mem_wren !== 1'b0) begin n_err++; $display("FAIL st_wren_after: got %b want 0", bus.mem_wren); end
  endtask

  task automatic test_contention();
    int ord [2][4];
    int waited;
    logic [3:0] exp_ack;
    ord[0] = '{0, 1, 2, 3};
    ord[1] = '{3, 0, 1, 2};
    // fresh reset so the round-robin pointer starts at 0
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) set_cmd(c, 1'b0, 16'(16'h0100 + c), 16'h0);
    step();
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        // single access by core2 moves the pointer to 3
        bus.req = 4'b0100;
        step();
        step();
        n_cmp++; if (bus.ack !== 4'b0100) begin n_err++; $display("FAIL rr_setup_ack: got %b want 0100", bus.ack); end
        bus.req = 4'b0;
        step();
      end
      bus.req = 4'b1111;
      for (int j = 0; j < 4; j++) begin
        exp_ack = 4'(1) << ord[r][j];
        waited = 0;
        step();
        waited++;
        while (bus.ack === 4'b0 && waited < 8) begin
          step();
          waited++;
        end
        n_cmp++; if (bus.ack !== exp_ack) begin n_err++; $display("FAIL rr%0d_ack%0d: got %b want %b", r, j, bus.ack, exp_ack); end
        n_cmp++; if (waited != 2) begin n_err++; $display("FAIL rr%0d_gap%0d: got %0d cycles want 2", r, j, waited); end
        n_cmp++; if (bus.mem_addr !== 16'(16'h0100 + ord[r][j])) begin n_err++; $display("FAIL rr%0d_addr%0d: got %h want %h", r, j, bus.mem_addr, 16'(16'h0100 + ord[r][j])); end
        bus.req[ord[r][j]] = 1'b0;
      end
      step();
      n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rr%0d_idle: got busy %b want 0", r, bus.busy); end
    end
  endtask

  task automatic test_stop();
    set_cmd(1, 1'b0, 16'h0201, 16'h0);
    set_cmd(2, 1'b0, 16'h0202, 16'h0);
    bus.req = 4'b0010;
    step();
    n_cmp++; if (bus.gnt_id !== 2'd1 || bus.busy !== 1'b1) begin n_err++; $display("FAIL stop_gnt1: got gnt %0d busy %b want 1 1", bus.gnt_id, bus.busy); end
    bus.stop = 1'b1;
    bus.req  = 4'b0110;
    step();
    n_cmp++; if (bus.ack !== 4'b0010) begin n_err++; $display("FAIL stop_ack1: got %b want 0010", bus.ack); end
    bus.req = 4'b0100;
    step();
    n_cmp++; if (bus.busy !== 1'b0 || bus.ack !== 4'b0) begin n_err++; $display("FAIL stop_hold: got busy %b ack %b want 0 0000", bus.busy, bus.ack); end
    step();
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL stop_hold2: got busy %b want 0", bus.busy); end
    bus.stop = 1'b0;
    step();
    n_cmp++; if (bus.busy !== 1'b1 || bus.gnt_id !== 2'd2) begin n_err++; $display("FAIL stop_resume: got busy %b gnt %0d want 1 2", bus.busy, bus.gnt_id); end
    step();
    n_cmp++; if (bus.ack !== 4'b0100) begin n_err++; $display("FAIL stop_ack2: got %b want 0100", bus.ack); end
    bus.req = 4'b0;
    step();
  endtask

  task automatic test_abort();
    set_cmd(3, 1'b1, 16'h0333, 16'hCAFE);
    bus.req = 4'b1000;
    step();
    n_cmp++; if (bus.mem_wren !== 1'b1 || bus.gnt_id !== 2'd3) begin n_err++; $display("FAIL abort_pre: got wren %b gnt %0d want 1 3", bus.mem_wren, bus.gnt_id); end
    #1;
    rstn = 1'b0;
    #1;
    n_cmp++; if (bus.mem_wren !== 1'b0) begin n_err++; $display("FAIL abort_wren: got %b want 0", bus.mem_wren); end
    n_cmp++; if (bus.ack !== 4'b0) begin n_err++; $display("FAIL abort_ack: got %b want 0000", bus.ack); end
    bus.req = 4'b0;
    bus.we  = 4'b0;
    step();
    rstn = 1'b1;
    step();
    n_cmp++; if (bus.busy !== 1'b0 || bus.gnt_id !== 2'd0) begin n_err++; $display("FAIL abort_after: got busy %b gnt %0d want 0 0", bus.busy, bus.gnt_id); end
    n_cmp++; if (bus.ack !== 4'b0) begin n_err++; $display("FAIL abort_noack: got %b want 0000", bus.ack); end
  endtask

  initial begin
    test_reset();
    test_single_load();
    test_single_store();
    test_contention();
    test_stop();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
